// File: rtl/fetch_bp_unit.sv
// IF stage with PC, IF/ID register and a 2-bit-counter branch history table.
// Optional FETCH_PERF_CNT_EN adds branch and mispredict counters.
module fetch_bp_unit #(
  parameter int                 XLEN      = 32,
  parameter int                 BHT_IDX_W = 4,
  parameter logic [XLEN-1:0]    RESET_PC  = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            stall_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [31:0]     imem_instr_i,
  output logic [XLEN-1:0] ifid_pc_o,
  output logic [31:0]     ifid_instr_o,
  output logic            ifid_valid_o,
  output logic            ifid_pred_o,
  input  logic            br_valid_i,
  input  logic [XLEN-1:0] br_pc_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            br_pred_i
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_br_cnt_o,
  output logic [31:0]     perf_mispred_cnt_o
`endif
);

  localparam int NBHT = 1 << BHT_IDX_W;

  logic [XLEN-1:0]      r_pc;
  logic [XLEN-1:0]      r_ifid_pc;
  logic [31:0]          r_ifid_instr;
  logic                 r_ifid_valid;
  logic                 r_ifid_pred;
  logic [1:0]           r_bht [NBHT];

  logic                 w_is_br;
  logic [XLEN-1:0]      w_bimm;
  logic [BHT_IDX_W-1:0] w_idx;
  logic                 w_pred;
  logic                 w_res;
  logic                 w_mis;
  logic [XLEN-1:0]      w_fix_pc;
  logic [XLEN-1:0]      w_next_pc;
  logic [BHT_IDX_W-1:0] w_upd_idx;
  logic [1:0]           w_cnt_cur;
  logic [1:0]           w_cnt_nxt;

  assign imem_addr_o  = r_pc;
  assign ifid_pc_o    = r_ifid_pc;
  assign ifid_instr_o = r_ifid_instr;
  assign ifid_valid_o = r_ifid_valid;
  assign ifid_pred_o  = r_ifid_pred;

  assign w_is_br = (imem_instr_i[6:0] == 7'b1100011);
  assign w_bimm  = {{(XLEN-13){imem_instr_i[31]}},
                    imem_instr_i[31], imem_instr_i[7],
                    imem_instr_i[30:25], imem_instr_i[11:8],
                    1'b0};
  assign w_idx   = r_pc[BHT_IDX_W+1:2];
  // Prediction reads the counter before any same-cycle update.
  assign w_pred  = w_is_br && r_bht[w_idx][1];

  assign w_res    = br_valid_i && !stall_i;
  assign w_mis    = w_res && (br_pred_i != br_taken_i);
  assign w_fix_pc = br_taken_i ? br_target_i
                               : br_pc_i + XLEN'(4);
  assign w_next_pc = w_pred ? r_pc + w_bimm
                            : r_pc + XLEN'(4);

  assign w_upd_idx = br_pc_i[BHT_IDX_W+1:2];
  assign w_cnt_cur = r_bht[w_upd_idx];

  always_comb begin
    w_cnt_nxt = w_cnt_cur;
    if (br_taken_i) begin
      if (w_cnt_cur != 2'b11) w_cnt_nxt = w_cnt_cur + 2'b01;
    end else begin
      if (w_cnt_cur != 2'b00) w_cnt_nxt = w_cnt_cur - 2'b01;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc         <= RESET_PC;
      r_ifid_pc    <= '0;
      r_ifid_instr <= '0;
      r_ifid_valid <= 1'b0;
      r_ifid_pred  <= 1'b0;
    end else if (w_mis) begin
      r_pc         <= w_fix_pc;
      r_ifid_valid <= 1'b0;
      r_ifid_pred  <= 1'b0;
    end else if (!stall_i) begin
      if (start_i) begin
        r_pc         <= w_next_pc;
        r_ifid_pc    <= r_pc;
        r_ifid_instr <= imem_instr_i;
        r_ifid_valid <= 1'b1;
        r_ifid_pred  <= w_pred;
      end else begin
        r_ifid_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < NBHT; k++) r_bht[k] <= 2'b01;
    end else if (w_res) begin
      r_bht[w_upd_idx] <= w_cnt_nxt;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_br_cnt;
  logic [31:0] r_mis_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else begin
      if (w_res) r_br_cnt  <= r_br_cnt + 32'd1;
      if (w_mis) r_mis_cnt <= r_mis_cnt + 32'd1;
    end
  end

  assign perf_br_cnt_o      = r_br_cnt;
  assign perf_mispred_cnt_o = r_mis_cnt;
`endif

endmodule

// File: tb/tb_fetch_bp_unit.sv
// Directed bench for fetch_bp_unit: straight-line fetch, stall, mispredict,
// loop prediction, counter saturation/decrement and async reset.
module tb_fetch_bp_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stall;
  logic [31:0] addr;
  logic [31:0] instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        ifid_pred;
  logic        br_valid;
  logic [31:0] br_pc;
  logic        br_taken;
  logic [31:0] br_target;
  logic        br_pred;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_br;
  logic [31:0] perf_mis;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [31:0] beq(input logic [12:0] off);
    return {off[12], off[10:5], 5'd0, 5'd0, 3'b000,
            off[4:1], off[11], 7'b1100011};
  endfunction

  logic [31:0] beq_a;
  logic [31:0] beq_b;
  logic [31:0] beq_l;
  assign beq_a = beq(13'h00F4);
  assign beq_b = beq(13'h1E20);
  assign beq_l = beq(13'h1FF0);

  always_comb begin
    case (addr)
      32'h10C: instr = beq_a;
      32'h200: instr = beq_b;
      32'h020: instr = beq_l;
      default: instr = NOP;
    endcase
  end

  fetch_bp_unit #(
    .XLEN(32), .BHT_IDX_W(4), .RESET_PC(32'h100)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(start),
    .stall_i(stall),
    .imem_addr_o(addr),
    .imem_instr_i(instr),
    .ifid_pc_o(ifid_pc),
    .ifid_instr_o(ifid_instr),
    .ifid_valid_o(ifid_valid),
    .ifid_pred_o(ifid_pred),
    .br_valid_i(br_valid),
    .br_pc_i(br_pc),
    .br_taken_i(br_taken),
    .br_target_i(br_target),
    .br_pred_i(br_pred)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_br_cnt_o(perf_br),
    .perf_mispred_cnt_o(perf_mis)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic pr);
    br_valid  = 1'b1;
    br_pc     = pc;
    br_taken  = tk;
    br_target = tgt;
    br_pred   = pr;
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    br_valid = 1'b0; br_pc = '0; br_taken = 1'b0;
    br_target = '0; br_pred = 1'b0;
    #2 rst = 1'b0;
    tick(); tick();
    chk("rst_addr", addr, 32'h100);
    chk("rst_ifpc", ifid_pc, 32'h0);
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_pred", {31'd0, ifid_pred}, 32'd0);
    @(negedge clk);
    rst = 1'b1; start = 1'b1;

    tick();
    chk("e1_addr", addr, 32'h104);
    chk("e1_ifpc", ifid_pc, 32'h100);
    chk("e1_valid", {31'd0, ifid_valid}, 32'd1);
    chk("e1_instr", ifid_instr, NOP);
    tick();
    chk("e2_addr", addr, 32'h108);
    chk("e2_ifpc", ifid_pc, 32'h104);
    stall = 1'b1;

    tick();
    chk("st1_addr", addr, 32'h108);
    chk("st1_ifpc", ifid_pc, 32'h104);
    resolve(32'h10C, 1'b1, 32'h300, 1'b0);
    tick();
    chk("st2_addr", addr, 32'h108);
    chk("st2_ifpc", ifid_pc, 32'h104);
    chk("st2_valid", {31'd0, ifid_valid}, 32'd1);
    stall = 1'b0; br_valid = 1'b0;

    tick();
    chk("e5_addr", addr, 32'h10C);
    tick();
    chk("e6_ifpc", ifid_pc, 32'h10C);
    chk("e6_instr", ifid_instr, beq_a);
    chk("e6_pred", {31'd0, ifid_pred}, 32'd0);
    chk("e6_addr", addr, 32'h110);
    resolve(32'h10C, 1'b1, 32'h200, 1'b0);
    tick();
    chk("mis1_addr", addr, 32'h200);
    chk("mis1_valid", {31'd0, ifid_valid}, 32'd0);
    br_valid = 1'b0;
    tick();
    chk("e8_ifpc", ifid_pc, 32'h200);
    chk("e8_pred", {31'd0, ifid_pred}, 32'd0);
    resolve(32'h200, 1'b1, 32'h20, 1'b0);
    tick();
    chk("mis2_addr", addr, 32'h20);
    chk("mis2_valid", {31'd0, ifid_valid}, 32'd0);
    br_valid = 1'b0;

    tick();
    chk("l1_pred", {31'd0, ifid_pred}, 32'd0);
    chk("l1_addr", addr, 32'h24);
    resolve(32'h20, 1'b1, 32'h10, 1'b0);
    tick();
    chk("l1r_addr", addr, 32'h10);
    br_valid = 1'b0;
    repeat (4) tick();
    chk("l2_fetch", addr, 32'h20);
    tick();
    chk("l2_pred", {31'd0, ifid_pred}, 32'd1);
    chk("l2_addr", addr, 32'h10);
    resolve(32'h20, 1'b1, 32'h10, 1'b1);
    tick();
    chk("l2r_addr", addr, 32'h14);
    chk("l2r_valid", {31'd0, ifid_valid}, 32'd1);
    chk("l2r_ifpc", ifid_pc, 32'h10);
    br_valid = 1'b0;
    repeat (3) tick();
    chk("l3_fetch", addr, 32'h20);
    tick();
    chk("l3_pred", {31'd0, ifid_pred}, 32'd1);
    chk("l3_addr", addr, 32'h10);
    resolve(32'h20, 1'b0, 32'h10, 1'b1);
    tick();
    chk("nt_addr", addr, 32'h24);
    chk("nt_valid", {31'd0, ifid_valid}, 32'd0);
    chk("nt_pred", {31'd0, ifid_pred}, 32'd0);
    br_valid = 1'b0;

    n = 0;
    while (addr != 32'h10C && n < 100) begin
      tick();
      n++;
    end
    chk("walk", addr, 32'h10C);
    tick();
    chk("a_pred", {31'd0, ifid_pred}, 32'd1);
    chk("a_addr", addr, 32'h200);
    chk("a_valid", {31'd0, ifid_valid}, 32'd1);
    tick();
    chk("b_pred", {31'd0, ifid_pred}, 32'd1);
    chk("b_addr", addr, 32'h20);
    tick();
    chk("w_pred", {31'd0, ifid_pred}, 32'd1);
    chk("w_addr", addr, 32'h10);

`ifdef FETCH_PERF_CNT_EN
    chk("perf_br", perf_br, 32'd5);
    chk("perf_mis", perf_mis, 32'd4);
`endif

    start = 1'b0;
    tick();
    chk("idle_addr", addr, 32'h10);
    chk("idle_valid", {31'd0, ifid_valid}, 32'd0);

    #2 rst = 1'b0;
    #1;
    chk("arst_addr", addr, 32'h100);
    chk("arst_valid", {31'd0, ifid_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
